// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo
// Description : Single-clock parameterised FIFO with a fill count,
//               programmable almost-full/almost-empty thresholds, a
//               synchronous flush and sticky overflow/underflow flags.
//               Build option: define FIFO_FWFT_EN for first-word-fall-through
//               read data. Otherwise data_out is registered, 1-cycle latency.
// Ports       : clk           clock, all state on rising edge
//               rst           asynchronous reset, active low
//               flush         synchronous clear of contents (wins over we/re)
//               we / data_in  write request / write data
//               re            read request
//               data_out      read data
//               full, empty, almost_full, almost_empty, count  status
//               overflow, underflow  sticky error flags
//               clr_err       synchronous clear of the error flags
// Revision    : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   we,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   re,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_AF    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] c_AE    = (AW+1)'(AE_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  // Status is decoded from the registered count only, so flags never
  // depend combinationally on we/re.
  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  // Acceptance uses the pre-edge state: a read cannot make room for a
  // same-cycle write into a full FIFO, nor a write feed a same-cycle read
  // from an empty one.
  assign w_wr_en = we & ~w_full  & ~flush;
  assign w_rd_en = re & ~w_empty & ~flush;

  // Storage has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky errors: a new event in the same cycle as clr_err leaves the flag
  // set. Attempts made during a flush are not errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~clr_err) | (we & w_full  & ~flush);
      r_udf <= (r_udf & ~clr_err) | (re & w_empty & ~flush);
    end
  end

`ifdef FIFO_FWFT_EN
  // Head of queue is always presented; forced to zero while empty.
  assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [WIDTH-1:0] r_dout;

  // Loads only on an accepted read; holds through idle cycles, underflow
  // attempts and flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else if (w_rd_en) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign data_out = r_dout;
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_AF);
  assign almost_empty = (r_count <= c_AE);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_sync_fifo
// Description : Self-checking bench for param_sync_fifo (WIDTH=8, DEPTH=16).
//               A queue-based reference model predicts every output. The
//               bench follows the FIFO_FWFT_EN define for read-data timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int AF_THRESH = DEPTH - 2;
  localparam int AE_THRESH = 2;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       flush   = 1'b0;
  logic       we      = 1'b0;
  logic       re      = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .we           (we),
    .data_in      (data_in),
    .re           (re),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  string phase   = "init";

  // Reference model: a plain queue of stored words plus the expected
  // data_out and sticky flags.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic [7:0] m_pop;
  bit         m_ovf;
  bit         m_udf;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL [%s] %s: got %0h expected %0h", phase, nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_edge(bit f, bit w, logic [7:0] d, bit r, bit c);
    bit was_full, was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_ovf = (m_ovf && !c) || (w && was_full  && !f);
    m_udf = (m_udf && !c) || (r && was_empty && !f);
    if (f) begin
      mq.delete();
    end else begin
      if (r && !was_empty) begin
        m_pop = mq.pop_front();
`ifndef FIFO_FWFT_EN
        m_dout = m_pop;
`endif
      end
      if (w && !was_full) mq.push_back(d);
    end
`ifdef FIFO_FWFT_EN
    m_dout = (mq.size() == 0) ? 8'h00 : mq[0];
`endif
  endtask

  task automatic cmp_model();
    int n;
    n = mq.size();
    chk("count",        32'(count),        32'(n));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("full",         32'(full),         32'(n == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(n >= AF_THRESH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE_THRESH));
    chk("data_out",     32'(data_out),     32'(m_dout));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(bit f, bit w, logic [7:0] d, bit r, bit c);
    flush = f; we = w; data_in = d; re = r; clr_err = c;
    @(posedge clk);
    #1;
    model_edge(f, w, d, r, c);
    cmp_model();
  endtask

  typedef struct {
    bit         f, w;
    logic [7:0] d;
    bit         r, c;
    int         cnt;
    bit         emp;
    logic [7:0] dstd, dfw;
    bit         ovf, udf;
  } vec_t;

  vec_t tv[13];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] exp_d;
    int         wp;

    //          f  w  d      r  c  cnt emp dstd   dfw    ovf udf
    tv[0]  = '{0, 1, 8'h11, 0, 0, 1,  0,  8'h00, 8'h11, 0,  0};
    tv[1]  = '{0, 1, 8'h22, 0, 0, 2,  0,  8'h00, 8'h11, 0,  0};
    tv[2]  = '{0, 0, 8'h00, 1, 0, 1,  0,  8'h11, 8'h22, 0,  0};
    tv[3]  = '{0, 1, 8'h33, 1, 0, 1,  0,  8'h22, 8'h33, 0,  0};
    tv[4]  = '{0, 0, 8'h00, 1, 0, 0,  1,  8'h33, 8'h00, 0,  0};
    tv[5]  = '{0, 0, 8'h00, 1, 0, 0,  1,  8'h33, 8'h00, 0,  1};
    tv[6]  = '{0, 0, 8'h00, 0, 1, 0,  1,  8'h33, 8'h00, 0,  0};
    tv[7]  = '{1, 1, 8'h44, 0, 0, 0,  1,  8'h33, 8'h00, 0,  0};
    tv[8]  = '{0, 0, 8'h00, 1, 0, 0,  1,  8'h33, 8'h00, 0,  1};
    tv[9]  = '{0, 0, 8'h00, 1, 1, 0,  1,  8'h33, 8'h00, 0,  1};
    tv[10] = '{0, 0, 8'h00, 0, 1, 0,  1,  8'h33, 8'h00, 0,  0};
    tv[11] = '{0, 1, 8'h55, 0, 0, 1,  0,  8'h33, 8'h55, 0,  0};
    tv[12] = '{1, 0, 8'h00, 0, 0, 0,  1,  8'h33, 8'h00, 0,  0};

    // 1: reset state
    phase = "reset";
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst empty",        32'(empty),        32'd1);
    chk("rst full",         32'(full),         32'd0);
    chk("rst count",        32'(count),        32'd0);
    chk("rst almost_empty", 32'(almost_empty), 32'd1);
    chk("rst almost_full",  32'(almost_full),  32'd0);
    chk("rst data_out",     32'(data_out),     32'h00);
    chk("rst errors",       32'({overflow, underflow}), 32'd0);
    rst = 1'b1;

    // Table of short explicit vectors
    phase = "table";
    for (int i = 0; i < 13; i++) begin
      step(tv[i].f, tv[i].w, tv[i].d, tv[i].r, tv[i].c);
      chk($sformatf("tv%0d count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("tv%0d empty", i), 32'(empty), 32'(tv[i].emp));
`ifdef FIFO_FWFT_EN
      chk($sformatf("tv%0d data_out", i), 32'(data_out), 32'(tv[i].dfw));
`else
      chk($sformatf("tv%0d data_out", i), 32'(data_out), 32'(tv[i].dstd));
`endif
      chk($sformatf("tv%0d overflow", i),  32'(overflow),  32'(tv[i].ovf));
      chk($sformatf("tv%0d underflow", i), 32'(underflow), 32'(tv[i].udf));
    end

    // 2: fill to full, then overflow attempt
    phase = "fill";
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(i), 0, 0);
      chk("af ramp", 32'(almost_full), 32'((i + 1) >= 14));
    end
    chk("full after 16", 32'(full), 32'd1);
    step(0, 1, 8'hAA, 0, 0);
    chk("overflow set", 32'(overflow), 32'd1);
    chk("count stays 16", 32'(count), 32'd16);

    // 3: drain in order, then underflow and error clear
    phase = "drain";
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 1, 0);
`ifdef FIFO_FWFT_EN
      exp_d = (i < 15) ? 8'(i + 1) : 8'h00;
`else
      exp_d = 8'(i);
`endif
      chk("drain order", 32'(data_out), 32'(exp_d));
    end
    chk("empty after drain", 32'(empty), 32'd1);
    step(0, 0, 8'h00, 1, 0);
    chk("underflow set", 32'(underflow), 32'd1);
`ifdef FIFO_FWFT_EN
    chk("dout while empty", 32'(data_out), 32'h00);
`else
    chk("dout holds 0F", 32'(data_out), 32'h0F);
`endif
    step(0, 0, 8'h00, 0, 1);
    chk("errors cleared", 32'({overflow, underflow}), 32'd0);

    // 4: steady state at count 8 with simultaneous read/write
    phase = "steady";
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 8'(8'hC0 + i), 1, 0);
      chk("steady count", 32'(count), 32'd8);
    end

    // 5: flush beats a same-cycle write
    phase = "flush";
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
    chk("count 5", 32'(count), 32'd5);
    step(1, 1, 8'h77, 0, 0);
    chk("flush count", 32'(count), 32'd0);
    chk("flush empty", 32'(empty), 32'd1);
    step(0, 0, 8'h00, 1, 0);
    chk("77 not stored", 32'(underflow), 32'd1);
    step(0, 0, 8'h00, 0, 1);

    // 6: asynchronous reset in the middle of a burst
    phase = "async_rst";
    for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
    chk("count 7", 32'(count), 32'd7);
    #2 rst = 1'b0;
    #1;
    chk("async count", 32'(count), 32'd0);
    chk("async empty", 32'(empty), 32'd1);
    chk("async data_out", 32'(data_out), 32'h00);
    model_reset();
    #3 rst = 1'b1;
    step(0, 1, 8'h5A, 0, 0);
    step(0, 0, 8'h00, 0, 0);
`ifdef FIFO_FWFT_EN
    chk("fwft head", 32'(data_out), 32'h5A);
`else
    chk("no read yet", 32'(data_out), 32'h00);
`endif
    step(0, 0, 8'h00, 1, 0);
`ifndef FIFO_FWFT_EN
    chk("read 5A", 32'(data_out), 32'h5A);
`endif

    // Randomized traffic with phases biased toward full and toward empty
    phase = "random";
    for (int seg = 0; seg < 4; seg++) begin
      wp = (seg == 0) ? 80 : (seg == 1) ? 20 : 50;
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(99) < 3,
             $urandom_range(99) < wp,
             8'($urandom),
             $urandom_range(99) < (100 - wp),
             $urandom_range(99) < 5);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
